// File: rtl/axi4_fic_pkg.sv
// Shared widths, payload layouts and pack/unpack helpers for the FIC AXI4 register slice.
// Skid occupancy encoding keeps bit 0 = main entry valid, bit 1 = skid entry valid.
package axi4_fic_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 64;
    localparam int ID_WIDTH   = 4;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam int AX_W = ADDR_WIDTH + 2 + ID_WIDTH + 8 + 2;
    localparam int W_W  = DATA_WIDTH + STRB_WIDTH + 1;
    localparam int B_W  = ID_WIDTH + 2;
    localparam int R_W  = DATA_WIDTH + ID_WIDTH + 1 + 2;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b11
    } skid_state_e;

    typedef struct packed {
        skid_state_e aw;
        skid_state_e w;
        skid_state_e b;
        skid_state_e ar;
        skid_state_e r;
    } slice_dbg_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            burst;
        logic [ID_WIDTH-1:0]   id;
        logic [7:0]            len;
        logic [1:0]            size;
    } ax_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic                  last;
    } w_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [1:0]          resp;
    } b_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
        logic                  last;
        logic [1:0]            resp;
    } r_t;

    function automatic logic [AX_W-1:0] pack_ax(input logic [ADDR_WIDTH-1:0] addr,
                                                input logic [1:0] burst,
                                                input logic [ID_WIDTH-1:0] id,
                                                input logic [7:0] len,
                                                input logic [1:0] size);
        return {addr, burst, id, len, size};
    endfunction

    function automatic ax_t unpack_ax(input logic [AX_W-1:0] v);
        return ax_t'(v);
    endfunction

    function automatic logic [W_W-1:0] pack_w(input logic [DATA_WIDTH-1:0] data,
                                              input logic [STRB_WIDTH-1:0] strb,
                                              input logic last);
        return {data, strb, last};
    endfunction

    function automatic w_t unpack_w(input logic [W_W-1:0] v);
        return w_t'(v);
    endfunction

    function automatic logic [B_W-1:0] pack_b(input logic [ID_WIDTH-1:0] id,
                                              input logic [1:0] resp);
        return {id, resp};
    endfunction

    function automatic b_t unpack_b(input logic [B_W-1:0] v);
        return b_t'(v);
    endfunction

    function automatic logic [R_W-1:0] pack_r(input logic [DATA_WIDTH-1:0] data,
                                              input logic [ID_WIDTH-1:0] id,
                                              input logic last,
                                              input logic [1:0] resp);
        return {data, id, last, resp};
    endfunction

    function automatic r_t unpack_r(input logic [R_W-1:0] v);
        return r_t'(v);
    endfunction

endpackage

// File: rtl/axi4_fic_reg_slice_if.sv
// Five-channel AXI4 bundle used on both sides of the register slice.
// Handshake: a beat transfers on a clock edge where VALID and READY are both high; a source
// holds VALID and payload stable until that edge, and READY may change freely.
interface axi4_fic_reg_slice_if;
    import axi4_fic_pkg::*;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [1:0]            awburst;
    logic [ID_WIDTH-1:0]   awid;
    logic [7:0]            awlen;
    logic [1:0]            awsize;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [1:0]            arburst;
    logic [ID_WIDTH-1:0]   arid;
    logic [7:0]            arlen;
    logic [1:0]            arsize;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ID_WIDTH-1:0]   rid;
    logic                  rlast;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awburst, awid, awlen, awsize,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, araddr, arburst, arid, arlen, arsize,
        input  arready,
        input  rvalid, rdata, rid, rlast, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awburst, awid, awlen, awsize,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, araddr, arburst, arid, arlen, arsize,
        output arready,
        output rvalid, rdata, rid, rlast, rresp,
        input  rready
    );

endinterface

// File: rtl/axi_skid_buffer.sv
// Two-entry skid buffer: main entry drives the output, skid entry absorbs one beat when the
// consumer stalls. VALID, READY and payload all come straight from flops.
module axi_skid_buffer
    import axi4_fic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output skid_state_e      o_state
);

    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_m_data;
    logic [WIDTH-1:0] r_s_data;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_load_m_in;
    logic             w_load_m_skid;
    logic             w_load_s;

    // State bit 0 is the main-entry valid flag, so the output handshake needs no decode.
    assign w_in_hs  = i_in_valid & r_in_ready;
    assign w_out_hs = r_state[0] & i_out_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_load_m_in   = 1'b0;
        w_load_m_skid = 1'b0;
        w_load_s      = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_in_hs) begin
                    w_state_nxt = SKID_ONE;
                    w_load_m_in = 1'b1;
                end
            end
            SKID_ONE: begin
                if (w_in_hs && w_out_hs) begin
                    w_load_m_in = 1'b1;
                end else if (w_in_hs) begin
                    w_state_nxt = SKID_FULL;
                    w_load_s    = 1'b1;
                end else if (w_out_hs) begin
                    w_state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (w_out_hs) begin
                    w_state_nxt   = SKID_ONE;
                    w_load_m_skid = 1'b1;
                end
            end
            default: w_state_nxt = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= SKID_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != SKID_FULL);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_m_data <= '0;
            r_s_data <= '0;
        end else begin
            if (w_load_m_in) begin
                r_m_data <= i_in_data;
            end else if (w_load_m_skid) begin
                r_m_data <= r_s_data;
            end
            if (w_load_s) begin
                r_s_data <= i_in_data;
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_state[0];
    assign o_out_data  = r_m_data;
    assign o_state     = r_state;

endmodule

// File: rtl/axi4_fic_reg_slice.sv
// AXI4 register slice between the fabric initiator and the FIC address shim: one skid buffer
// per channel, AW/W/AR flow target->initiator, B/R flow initiator->target.
module axi4_fic_reg_slice
    import axi4_fic_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    axi4_fic_reg_slice_if.slave   io_tgt,
    axi4_fic_reg_slice_if.master  io_ini,
    output slice_dbg_t            o_dbg
);

    logic [AX_W-1:0] w_aw_in;
    logic [AX_W-1:0] w_aw_out;
    logic [W_W-1:0]  w_w_in;
    logic [W_W-1:0]  w_w_out;
    logic [B_W-1:0]  w_b_in;
    logic [B_W-1:0]  w_b_out;
    logic [AX_W-1:0] w_ar_in;
    logic [AX_W-1:0] w_ar_out;
    logic [R_W-1:0]  w_r_in;
    logic [R_W-1:0]  w_r_out;
    ax_t             w_aw_f;
    w_t              w_w_f;
    b_t              w_b_f;
    ax_t             w_ar_f;
    r_t              w_r_f;
    skid_state_e     w_aw_state;
    skid_state_e     w_w_state;
    skid_state_e     w_b_state;
    skid_state_e     w_ar_state;
    skid_state_e     w_r_state;

    assign w_aw_in = pack_ax(io_tgt.awaddr, io_tgt.awburst, io_tgt.awid, io_tgt.awlen, io_tgt.awsize);
    assign w_w_in  = pack_w(io_tgt.wdata, io_tgt.wstrb, io_tgt.wlast);
    assign w_b_in  = pack_b(io_ini.bid, io_ini.bresp);
    assign w_ar_in = pack_ax(io_tgt.araddr, io_tgt.arburst, io_tgt.arid, io_tgt.arlen, io_tgt.arsize);
    assign w_r_in  = pack_r(io_ini.rdata, io_ini.rid, io_ini.rlast, io_ini.rresp);

    axi_skid_buffer #(.WIDTH(AX_W)) u_aw (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_in_valid  (io_tgt.awvalid),
        .o_in_ready  (io_tgt.awready),
        .i_in_data   (w_aw_in),
        .o_out_valid (io_ini.awvalid),
        .i_out_ready (io_ini.awready),
        .o_out_data  (w_aw_out),
        .o_state     (w_aw_state)
    );

    axi_skid_buffer #(.WIDTH(W_W)) u_w (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_in_valid  (io_tgt.wvalid),
        .o_in_ready  (io_tgt.wready),
        .i_in_data   (w_w_in),
        .o_out_valid (io_ini.wvalid),
        .i_out_ready (io_ini.wready),
        .o_out_data  (w_w_out),
        .o_state     (w_w_state)
    );

    axi_skid_buffer #(.WIDTH(B_W)) u_b (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_in_valid  (io_ini.bvalid),
        .o_in_ready  (io_ini.bready),
        .i_in_data   (w_b_in),
        .o_out_valid (io_tgt.bvalid),
        .i_out_ready (io_tgt.bready),
        .o_out_data  (w_b_out),
        .o_state     (w_b_state)
    );

    axi_skid_buffer #(.WIDTH(AX_W)) u_ar (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_in_valid  (io_tgt.arvalid),
        .o_in_ready  (io_tgt.arready),
        .i_in_data   (w_ar_in),
        .o_out_valid (io_ini.arvalid),
        .i_out_ready (io_ini.arready),
        .o_out_data  (w_ar_out),
        .o_state     (w_ar_state)
    );

    axi_skid_buffer #(.WIDTH(R_W)) u_r (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_in_valid  (io_ini.rvalid),
        .o_in_ready  (io_ini.rready),
        .i_in_data   (w_r_in),
        .o_out_valid (io_tgt.rvalid),
        .i_out_ready (io_tgt.rready),
        .o_out_data  (w_r_out),
        .o_state     (w_r_state)
    );

    assign w_aw_f = unpack_ax(w_aw_out);
    assign w_w_f  = unpack_w(w_w_out);
    assign w_b_f  = unpack_b(w_b_out);
    assign w_ar_f = unpack_ax(w_ar_out);
    assign w_r_f  = unpack_r(w_r_out);

    assign io_ini.awaddr  = w_aw_f.addr;
    assign io_ini.awburst = w_aw_f.burst;
    assign io_ini.awid    = w_aw_f.id;
    assign io_ini.awlen   = w_aw_f.len;
    assign io_ini.awsize  = w_aw_f.size;

    assign io_ini.wdata = w_w_f.data;
    assign io_ini.wstrb = w_w_f.strb;
    assign io_ini.wlast = w_w_f.last;

    assign io_tgt.bid   = w_b_f.id;
    assign io_tgt.bresp = w_b_f.resp;

    assign io_ini.araddr  = w_ar_f.addr;
    assign io_ini.arburst = w_ar_f.burst;
    assign io_ini.arid    = w_ar_f.id;
    assign io_ini.arlen   = w_ar_f.len;
    assign io_ini.arsize  = w_ar_f.size;

    assign io_tgt.rdata = w_r_f.data;
    assign io_tgt.rid   = w_r_f.id;
    assign io_tgt.rlast = w_r_f.last;
    assign io_tgt.rresp = w_r_f.resp;

    assign o_dbg = '{aw: w_aw_state, w: w_w_state, b: w_b_state, ar: w_ar_state, r: w_r_state};

endmodule
